sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single SRAM controller between two requesters: port 0 (MEM-stage data access)
//  and port 1 (secondary master, e.g. loader/debug). Round-robin arbitration, latches the
//  winner's command, sequences the controller's rd/wr enables until its ready, returns read
//  data with a one-cycle ack, and aborts hung accesses with a watchdog.
// PARAMETERS
//  AW       32  address width (byte address, passed through unchanged)
//  DW       32  data width
//  TIMEOUT  31  max BUSY cycles waiting for mem_ready before abort (>=2)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  req0/req1   in   1   port request; held high with cmd stable until ackN
//  we0/we1     in   1   1 = write, 0 = read
//  addr0/addr1 in   AW  byte address
//  wdata0/1    in   DW  write data
//  ack0/ack1   out  1   one-cycle completion pulse
//  err0/err1   out  1   one-cycle pulse, coincident with ackN, on watchdog abort
//  rdata0/1    out  DW  read data, valid in ackN cycle, held until next ackN
//  stall0/1    out  1   reqN & ~ackN (combinational), pipeline freeze
//  mem_rd_en   out  1   read enable to SRAM controller
//  mem_wr_en   out  1   write enable to SRAM controller
//  mem_addr    out  AW  latched address to controller
//  mem_wdata   out  DW  latched write data to controller
//  mem_rdata   in   DW  read data from controller
//  mem_ready   in   1   controller done
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, rr_ptr=1 (port 0 wins first tie), all ack/err=0,
//   mem_rd_en=mem_wr_en=0, mem_addr/mem_wdata/rdata0/rdata1=0, wdog=0.
//  States: IDLE -> BUSY -> RELEASE -> IDLE.
//  IDLE: if req0|req1: winner = only requester, or on tie the port != rr_ptr. Latch
//   addr/wdata/we/winner into registers; next cycle BUSY with mem_wr_en=we, mem_rd_en=~we.
//   No request -> stay IDLE, enables 0.
//  BUSY: enables/addr/wdata held constant. wdog counts from 0 each BUSY cycle.
//   mem_ready ignored in first BUSY cycle (wdog==0). mem_ready=1 later: rdata<winner> <=
//   mem_rdata (reads only; writes leave rdata unchanged), ack<winner>=1 for that cycle,
//   rr_ptr<=winner, go RELEASE. wdog reaches TIMEOUT w/o ready: ack+err of winner pulse,
//   rdata<winner> <= 0 (reads), rr_ptr<=winner, go RELEASE.
//  RELEASE: enables forced 0 for exactly one cycle (controller returns to idle); acks 0;
//   requests ignored; then IDLE.
//  Latency: req sampled in IDLE at edge T -> enables high from T+1 -> ack in cycle after
//   first valid mem_ready; min request-to-ack = 3 cycles; back-to-back same port = ack + 2.
//  Simultaneous: req arriving in BUSY/RELEASE waits; loser keeps stall high. Same-cycle
//   req0&req1 in IDLE resolved by rr_ptr, strictly alternating under continuous load.
//  req dropped mid-BUSY (protocol violation): transaction still completes, ack still pulses.
//  mem_ready high in IDLE/RELEASE: ignored. ack0 and ack1 never high together.
//  Address/data widths pass through unmodified; no address translation in this block.
// TESTING
//  1 Read port0 only: addr0=0x400, mem_ready 5 cyc after enable, mem_rdata=0x12345678
//    -> mem_rd_en high 5 cyc, ack0 one pulse, rdata0=0x12345678, rdata1/ack1 unchanged.
//  2 Tie from reset: req0,req1 same cycle -> port 0 served first, port 1 served after
//    RELEASE; under held requests grants alternate 0,1,0,1.
//  3 Write port1 addr1=0x408 wdata1=0xCAFEF00D -> mem_wr_en=1, mem_addr=0x408,
//    mem_wdata=0xCAFEF00D stable all BUSY; ack1 pulse; rdata1 unchanged.
//  4 mem_ready stuck 1 from reset -> first BUSY cycle ignored, ack at BUSY cycle 2.
//  5 mem_ready never asserts, TIMEOUT=31 -> ack0&err0 pulse after 31 BUSY cycles, rdata0=0,
//    then RELEASE with enables 0, then next request accepted.
//  6 rst asserted mid-BUSY -> enables/ack drop same cycle (async), rr_ptr=1 after release.

Source files
------------

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two requesters, the SRAM port arbiter and the SRAM controller.
// The slave modport is the arbiter's view; master is the view of whatever drives the
// requesters and models the controller.
interface sram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic          err0;
    logic          err1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;
    logic          stall0;
    logic          stall1;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
        output ack0, ack1, err0, err1, rdata0, rdata1, stall0, stall1,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_ready,
        input  ack0, ack1, err0, err1, rdata0, rdata1, stall0, stall1,
               mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between the MEM-stage port (0) and a
// secondary master (1). The winning command is latched, the controller enables are held
// until mem_ready (ignored in the first BUSY cycle) or the watchdog expires, then a single
// RELEASE cycle with enables low lets the controller settle before the next grant.
module sram_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_port_arbiter_if.slave    bus
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } state_t;

    state_t        r_state;
    logic          r_rrPtr;
    logic          r_winner;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;
    logic          r_rdEn;
    logic          r_wrEn;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_err0;
    logic          r_err1;
    logic [WDW-1:0] r_wdog;

    logic          w_grant1;
    logic          w_done;
    logic          w_timeout;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign w_grant1  = bus.req1 & (~bus.req0 | ~r_rrPtr);
    assign w_done    = bus.mem_ready & (r_wdog != '0);
    assign w_timeout = (r_wdog == WDW'(TIMEOUT - 1));

    // Arbitration FSM: grant and latch in IDLE, wait for ready or abort in BUSY, cool down in RELEASE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rrPtr  <= 1'b1;
            r_winner <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_rdEn   <= 1'b0;
            r_wrEn   <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_err0 <= 1'b0;
            r_err1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req0 | bus.req1) begin
                        r_winner <= w_grant1;
                        r_we     <= w_grant1 ? bus.we1 : bus.we0;
                        r_addr   <= w_grant1 ? bus.addr1 : bus.addr0;
                        r_wdata  <= w_grant1 ? bus.wdata1 : bus.wdata0;
                        r_wrEn   <= w_grant1 ? bus.we1 : bus.we0;
                        r_rdEn   <= w_grant1 ? ~bus.we1 : ~bus.we0;
                        r_wdog   <= '0;
                        r_state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_done || w_timeout) begin
                        if (!r_winner) begin
                            r_ack0 <= 1'b1;
                            r_err0 <= ~w_done;
                            if (!r_we) begin
                                r_rdata0 <= w_done ? bus.mem_rdata : '0;
                            end
                        end else begin
                            r_ack1 <= 1'b1;
                            r_err1 <= ~w_done;
                            if (!r_we) begin
                                r_rdata1 <= w_done ? bus.mem_rdata : '0;
                            end
                        end
                        r_rrPtr <= r_winner;
                        r_rdEn  <= 1'b0;
                        r_wrEn  <= 1'b0;
                        r_state <= RELEASE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                RELEASE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = r_ack0;
    assign bus.ack1      = r_ack1;
    assign bus.err0      = r_err0;
    assign bus.err1      = r_err1;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.stall0    = bus.req0 & ~r_ack0;
    assign bus.stall1    = bus.req1 & ~r_ack1;
    assign bus.mem_rd_en = r_rdEn;
    assign bus.mem_wr_en = r_wrEn;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed testbench for sram_port_arbiter: a small controller model answers enables with
// mem_ready after a chosen number of enabled cycles, and each scenario task checks its own
// hand-computed expectations.
module tb_sram_port_arbiter;

    logic clk = 1'b0;
    logic rst;

    int errors = 0;
    int checks = 0;
    bit sawDualAck = 1'b0;
    bit sawStrayErr = 1'b0;

    int          edges;
    int          ackPort;
    int          rdCnt;
    int          wrCnt;
    bit          errAtAck;
    bit          stable;
    logic [31:0] capAddr;
    logic [31:0] capWdata;

    sram_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    sram_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(31)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case the bench itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout got=stuck want=finish");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.req0 = 1'b0;  bus.req1 = 1'b0;
        bus.we0 = 1'b0;   bus.we1 = 1'b0;
        bus.addr0 = '0;   bus.addr1 = '0;
        bus.wdata0 = '0;  bus.wdata1 = '0;
        bus.mem_rdata = '0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Controller model: raises mem_ready once readyAt enabled cycles have been seen
    // (readyAt==0 means ready from the start), records what the arbiter drove, stops on an ack.
    task automatic serve(input int readyAt, input logic [31:0] rdVal);
        bit first = 1'b1;
        edges = 0; ackPort = -1; rdCnt = 0; wrCnt = 0;
        errAtAck = 1'b0; stable = 1'b1; capAddr = '0; capWdata = '0;
        bus.mem_rdata = rdVal;
        bus.mem_ready = (readyAt == 0);
        for (int k = 0; k < 200 && ackPort < 0; k++) begin
            tick();
            edges++;
            if (bus.ack0 && bus.ack1) sawDualAck = 1'b1;
            if ((bus.err0 && !bus.ack0) || (bus.err1 && !bus.ack1)) sawStrayErr = 1'b1;
            if (bus.ack0 || bus.ack1) begin
                ackPort  = bus.ack0 ? 0 : 1;
                errAtAck = bus.ack0 ? bus.err0 : bus.err1;
            end else begin
                if (bus.mem_rd_en || bus.mem_wr_en) begin
                    if (bus.mem_rd_en) rdCnt++;
                    if (bus.mem_wr_en) wrCnt++;
                    if (first) begin
                        capAddr  = bus.mem_addr;
                        capWdata = bus.mem_wdata;
                        first    = 1'b0;
                    end else if (bus.mem_addr !== capAddr || bus.mem_wdata !== capWdata) begin
                        stable = 1'b0;
                    end
                end
                if (readyAt > 0 && (rdCnt + wrCnt) >= readyAt) bus.mem_ready = 1'b1;
            end
        end
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1;
        tick();
        checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack0 got=%b want=0", bus.ack0); end
        checks++; if (bus.ack1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack1 got=%b want=0", bus.ack1); end
        checks++; if (bus.err0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err0 got=%b want=0", bus.err0); end
        checks++; if (bus.err1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_err1 got=%b want=0", bus.err1); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en got=%b want=0", bus.mem_rd_en); end
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en got=%b want=0", bus.mem_wr_en); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h want=0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got=%h want=0", bus.mem_wdata); end
        checks++; if (bus.rdata0 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata0 got=%h want=0", bus.rdata0); end
        checks++; if (bus.rdata1 !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata1 got=%h want=0", bus.rdata1); end
        checks++; if (bus.stall0 !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall0 got=%b want=0", bus.stall0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_read_port0();
        logic [31:0] prev1;
        tick(); tick();
        prev1 = bus.rdata1;
        bus.addr0 = 32'h400; bus.we0 = 1'b0; bus.req0 = 1'b1;
        #1;
        checks++; if (bus.stall0 !== 1'b1) begin errors++; $display("[TB] FAIL rd0_stall_pending got=%b want=1", bus.stall0); end
        serve(5, 32'h12345678);
        checks++; if (ackPort != 0) begin errors++; $display("[TB] FAIL rd0_ack_port got=%0d want=0", ackPort); end
        checks++; if (rdCnt != 5) begin errors++; $display("[TB] FAIL rd0_rd_en_cycles got=%0d want=5", rdCnt); end
        checks++; if (wrCnt != 0) begin errors++; $display("[TB] FAIL rd0_wr_en_cycles got=%0d want=0", wrCnt); end
        checks++; if (edges != 6) begin errors++; $display("[TB] FAIL rd0_latency got=%0d want=6", edges); end
        checks++; if (capAddr !== 32'h400) begin errors++; $display("[TB] FAIL rd0_mem_addr got=%h want=400", capAddr); end
        checks++; if (errAtAck !== 1'b0) begin errors++; $display("[TB] FAIL rd0_err got=%b want=0", errAtAck); end
        checks++; if (bus.rdata0 !== 32'h12345678) begin errors++; $display("[TB] FAIL rd0_rdata0 got=%h want=12345678", bus.rdata0); end
        checks++; if (bus.rdata1 !== prev1) begin errors++; $display("[TB] FAIL rd0_rdata1_kept got=%h want=%h", bus.rdata1, prev1); end
        checks++; if (bus.stall0 !== 1'b0) begin errors++; $display("[TB] FAIL rd0_stall_at_ack got=%b want=0", bus.stall0); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rd0_release_rd_en got=%b want=0", bus.mem_rd_en); end
        bus.req0 = 1'b0;
        tick();
        checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("[TB] FAIL rd0_ack_one_cycle got=%b want=0", bus.ack0); end
        checks++; if (bus.rdata0 !== 32'h12345678) begin errors++; $display("[TB] FAIL rd0_rdata0_held got=%h want=12345678", bus.rdata0); end
    endtask

    task automatic test_tie();
        int          expPort;
        int          expEdges;
        logic [31:0] expData;
        logic [31:0] expAddr;
        logic [31:0] gotData;
        logic        otherStall;
        clearInputs();
        applyReset();
        bus.addr0 = 32'h100; bus.addr1 = 32'h200;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            expPort  = n % 2;
            expEdges = (n == 0) ? 3 : 4;
            expData  = 32'h1000 + n;
            expAddr  = (expPort == 1) ? 32'h200 : 32'h100;
            serve(2, expData);
            gotData    = (expPort == 1) ? bus.rdata1 : bus.rdata0;
            otherStall = (expPort == 1) ? bus.stall0 : bus.stall1;
            checks++; if (ackPort != expPort) begin errors++; $display("[TB] FAIL tie_grant%0d got=%0d want=%0d", n, ackPort, expPort); end
            checks++; if (edges != expEdges) begin errors++; $display("[TB] FAIL tie_latency%0d got=%0d want=%0d", n, edges, expEdges); end
            checks++; if (capAddr !== expAddr) begin errors++; $display("[TB] FAIL tie_addr%0d got=%h want=%h", n, capAddr, expAddr); end
            checks++; if (gotData !== expData) begin errors++; $display("[TB] FAIL tie_rdata%0d got=%h want=%h", n, gotData, expData); end
            checks++; if (otherStall !== 1'b1) begin errors++; $display("[TB] FAIL tie_loser_stall%0d got=%b want=1", n, otherStall); end
        end
        checks++; if (sawDualAck !== 1'b0) begin errors++; $display("[TB] FAIL tie_dual_ack got=%b want=0", sawDualAck); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    task automatic test_write_port1();
        logic [31:0] prev1;
        tick(); tick();
        prev1 = bus.rdata1;
        bus.addr1 = 32'h408; bus.wdata1 = 32'hCAFEF00D; bus.we1 = 1'b1; bus.req1 = 1'b1;
        serve(4, 32'hDEADBEEF);
        checks++; if (ackPort != 1) begin errors++; $display("[TB] FAIL wr1_ack_port got=%0d want=1", ackPort); end
        checks++; if (wrCnt != 4) begin errors++; $display("[TB] FAIL wr1_wr_en_cycles got=%0d want=4", wrCnt); end
        checks++; if (rdCnt != 0) begin errors++; $display("[TB] FAIL wr1_rd_en_cycles got=%0d want=0", rdCnt); end
        checks++; if (stable !== 1'b1) begin errors++; $display("[TB] FAIL wr1_cmd_stable got=%b want=1", stable); end
        checks++; if (capAddr !== 32'h408) begin errors++; $display("[TB] FAIL wr1_mem_addr got=%h want=408", capAddr); end
        checks++; if (capWdata !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL wr1_mem_wdata got=%h want=cafef00d", capWdata); end
        checks++; if (bus.rdata1 !== prev1) begin errors++; $display("[TB] FAIL wr1_rdata1_kept got=%h want=%h", bus.rdata1, prev1); end
        bus.req1 = 1'b0; bus.we1 = 1'b0;
        tick();
    endtask

    task automatic test_ready_stuck();
        clearInputs();
        bus.mem_ready = 1'b1;
        applyReset();
        tick(); tick();
        checks++; if ((bus.ack0 | bus.ack1 | bus.mem_rd_en) !== 1'b0) begin errors++; $display("[TB] FAIL stuck_idle_quiet got=%b want=0", bus.ack0 | bus.ack1 | bus.mem_rd_en); end
        bus.addr0 = 32'h40; bus.req0 = 1'b1;
        serve(0, 32'h5555AAAA);
        checks++; if (ackPort != 0) begin errors++; $display("[TB] FAIL stuck_ack_port got=%0d want=0", ackPort); end
        checks++; if (rdCnt != 2) begin errors++; $display("[TB] FAIL stuck_busy_cycles got=%0d want=2", rdCnt); end
        checks++; if (edges != 3) begin errors++; $display("[TB] FAIL stuck_latency got=%0d want=3", edges); end
        checks++; if (bus.rdata0 !== 32'h5555AAAA) begin errors++; $display("[TB] FAIL stuck_rdata0 got=%h want=5555aaaa", bus.rdata0); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        tick(); tick();
        bus.addr0 = 32'h80; bus.we0 = 1'b0; bus.req0 = 1'b1;
        serve(1000, 32'hFFFFFFFF);
        checks++; if (ackPort != 0) begin errors++; $display("[TB] FAIL wdog_ack_port got=%0d want=0", ackPort); end
        checks++; if (errAtAck !== 1'b1) begin errors++; $display("[TB] FAIL wdog_err0 got=%b want=1", errAtAck); end
        checks++; if (rdCnt != 31) begin errors++; $display("[TB] FAIL wdog_busy_cycles got=%0d want=31", rdCnt); end
        checks++; if (edges != 32) begin errors++; $display("[TB] FAIL wdog_latency got=%0d want=32", edges); end
        checks++; if (bus.rdata0 !== 32'h0) begin errors++; $display("[TB] FAIL wdog_rdata0 got=%h want=0", bus.rdata0); end
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL wdog_release_rd_en got=%b want=0", bus.mem_rd_en); end
        bus.req0 = 1'b0;
        tick();
        checks++; if (bus.err0 !== 1'b0) begin errors++; $display("[TB] FAIL wdog_err_one_cycle got=%b want=0", bus.err0); end
        bus.req0 = 1'b1;
        serve(2, 32'h00C0FFEE);
        checks++; if (ackPort != 0 || errAtAck !== 1'b0) begin errors++; $display("[TB] FAIL wdog_next_req got=port%0d/err%b want=port0/err0", ackPort, errAtAck); end
        checks++; if (bus.rdata0 !== 32'h00C0FFEE) begin errors++; $display("[TB] FAIL wdog_next_rdata0 got=%h want=00c0ffee", bus.rdata0); end
        checks++; if (sawStrayErr !== 1'b0) begin errors++; $display("[TB] FAIL wdog_stray_err got=%b want=0", sawStrayErr); end
        bus.req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        tick(); tick();
        bus.addr0 = 32'h10; bus.we0 = 1'b0; bus.req0 = 1'b1;
        serve(2, 32'h11);
        bus.req0 = 1'b0;
        tick(); tick();
        bus.addr0 = 32'h20; bus.req0 = 1'b1;
        tick();
        checks++; if (bus.mem_rd_en !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_busy_rd_en got=%b want=1", bus.mem_rd_en); end
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rd_en_async got=%b want=0", bus.mem_rd_en); end
        checks++; if (bus.ack0 !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ack0 got=%b want=0", bus.ack0); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_mem_addr got=%h want=0", bus.mem_addr); end
        tick();
        rst = 1'b0;
        bus.req0 = 1'b0;
        tick();
        bus.addr1 = 32'h30; bus.we1 = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        serve(2, 32'h22);
        checks++; if (ackPort != 0) begin errors++; $display("[TB] FAIL rstmid_rrptr_tie got=%0d want=0", ackPort); end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        clearInputs();
        rst = 1'b1;
        test_reset();
        test_read_port0();
        test_tie();
        test_write_port1();
        test_ready_stuck();
        test_timeout();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
